// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word fetches on req/gnt/rvalid,
// buffers returned words with their PCs and feeds the fetch side of IF/ID.
module if_fetch_unit #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = 32'h0000_0080,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_ctrl,
    input  logic                  branch_taken_i,
    input  logic [WORD_WIDTH-1:0] branch_target_i,
    output logic                  instr_req_o,
    output logic [WORD_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [WORD_WIDTH-1:0] instr_rdata_i,
    output logic                  instr_valid_o,
    output logic [WORD_WIDTH-1:0] program_count_o,
    output logic [WORD_WIDTH-1:0] pc_plus4_o,
    output logic [WORD_WIDTH-1:0] instruction_o
);

    // state    | meaning
    // BOOT     | one idle cycle after reset, no request
    // RUN      | normal prefetch
    // WAIT_GNT | request presented, held at pend_addr until granted
    typedef enum logic [1:0] {BOOT, RUN, WAIT_GNT} state_t;

    localparam int                    PW      = $clog2(FIFO_DEPTH);
    localparam int                    CW      = PW + 1;
    localparam logic [WORD_WIDTH-1:0] NOP     = WORD_WIDTH'(32'h0000_0013);
    localparam logic [WORD_WIDTH-1:0] FOUR    = WORD_WIDTH'(4);
    localparam logic [CW:0]           DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);

    state_t                state;
    logic [WORD_WIDTH-1:0] fetch_pc;
    logic [WORD_WIDTH-1:0] pend_addr;
    logic                  pend_discard;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         discard;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         pq_rd;
    logic [PW-1:0]         pq_wr;
    logic [WORD_WIDTH-1:0] pc_q      [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];

    logic                  pop;
    logic                  push;
    logic                  drop;
    logic                  gnt_fire;
    logic                  add_discard;
    logic [CW:0]           occupancy;
    logic [CW-1:0]         outstanding_nxt;
    logic [CW-1:0]         remain;
    logic [PW-1:0]         rd_nxt;
    logic [WORD_WIDTH-1:0] rsp_pc;
    logic                  head_valid;
    logic [WORD_WIDTH-1:0] head_pc;
    logic [WORD_WIDTH-1:0] head_data;

    // The slot freed by a same-cycle pop is credited to the issue check so a
    // two-entry buffer can sustain one instruction per cycle.
    always_comb begin
        pop             = instr_valid_o && !stall_ctrl && !branch_taken_i;
        occupancy       = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
        instr_req_o     = (state == WAIT_GNT) || ((state == RUN) && (occupancy < DEPTH_W));
        instr_addr_o    = (state == WAIT_GNT) ? pend_addr : fetch_pc;
        gnt_fire        = instr_req_o && instr_gnt_i;
        add_discard     = gnt_fire && (state == WAIT_GNT) && pend_discard;
        drop            = instr_rvalid_i && (discard != '0);
        push            = instr_rvalid_i && (discard == '0) && !branch_taken_i;
        rsp_pc          = pc_q[pq_rd];
        outstanding_nxt = outstanding + CW'(gnt_fire) - CW'(instr_rvalid_i);
        remain          = fifo_count - CW'(pop);
        rd_nxt          = rd_ptr + PW'(pop);
        head_valid      = !branch_taken_i && ((remain != '0) || push);
        if (remain == '0) begin
            head_pc   = rsp_pc;
            head_data = instr_rdata_i;
        end else begin
            head_pc   = fifo_pc[rd_nxt];
            head_data = fifo_data[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= BOOT;
            fetch_pc        <= BOOT_ADDR;
            pend_addr       <= BOOT_ADDR;
            pend_discard    <= 1'b0;
            outstanding     <= '0;
            discard         <= '0;
            fifo_count      <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            pq_rd           <= '0;
            pq_wr           <= '0;
            instr_valid_o   <= 1'b0;
            instruction_o   <= NOP;
            program_count_o <= '0;
            pc_plus4_o      <= FOUR;
        end else begin
            outstanding <= outstanding_nxt;

            // Every granted address is queued, kept or not, so responses pair up in order.
            if (gnt_fire) begin
                pc_q[pq_wr] <= instr_addr_o;
                pq_wr       <= pq_wr + PW'(1);
            end
            if (instr_rvalid_i)
                pq_rd <= pq_rd + PW'(1);

            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (instr_req_o && !instr_gnt_i) begin
                        state        <= WAIT_GNT;
                        pend_addr    <= fetch_pc;
                        pend_discard <= branch_taken_i;
                    end
                end
                WAIT_GNT: begin
                    if (instr_gnt_i) begin
                        state        <= RUN;
                        pend_discard <= 1'b0;
                    end else if (branch_taken_i) begin
                        pend_discard <= 1'b1;
                    end
                end
                default: state <= BOOT;
            endcase

            if (branch_taken_i)
                fetch_pc <= branch_target_i & ~WORD_WIDTH'(3);
            else if (gnt_fire && !add_discard)
                fetch_pc <= fetch_pc + FOUR;

            // After a redirect everything still in flight is stale.
            if (branch_taken_i)
                discard <= outstanding_nxt;
            else
                discard <= discard + CW'(add_discard) - CW'(drop);

            if (branch_taken_i) begin
                fifo_count <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]   <= rsp_pc;
                    fifo_data[wr_ptr] <= instr_rdata_i;
                    wr_ptr            <= wr_ptr + PW'(1);
                end
                rd_ptr     <= rd_nxt;
                fifo_count <= remain + CW'(push);
            end

            if (branch_taken_i || !stall_ctrl) begin
                instr_valid_o <= head_valid;
                if (head_valid) begin
                    program_count_o <= head_pc;
                    pc_plus4_o      <= head_pc + FOUR;
                    instruction_o   <= head_data;
                end else begin
                    instruction_o <= NOP;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == DEPTH_C)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized and directed bench for if_fetch_unit: a memory responder plus a
// program-order model of expected fetch addresses and delivered instructions.
module tb_if_fetch_unit;

    localparam int          D    = 2;
    localparam logic [31:0] BOOT = 32'h0000_0080;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_ctrl;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic [31:0] program_count_o;
    logic [31:0] pc_plus4_o;
    logic [31:0] instruction_o;

    if_fetch_unit #(.WORD_WIDTH(32), .BOOT_ADDR(BOOT), .FIFO_DEPTH(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_ctrl      (stall_ctrl),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .program_count_o (program_count_o),
        .pc_plus4_o      (pc_plus4_o),
        .instruction_o   (instruction_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem_q [$];
    logic [31:0] exp_pc, exp_fetch, last_grant, a_old;
    bit          skip_one, saw_wrap, got;
    int          outst, consumed, c0;
    int          gnt_mode, rv_mode;
    bit          rnd_stall, rnd_branch;

    logic        p_rst, p_req, p_gnt, p_rv, p_stall, p_br, p_valid;
    logic [31:0] p_addr, p_tgt, p_pc, p_pc4, p_ins;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory side and random control, applied just after each rising edge.
    task automatic drive();
        if (gnt_mode == 0)      instr_gnt_i = ($urandom_range(0, 99) < 60);
        else if (gnt_mode == 1) instr_gnt_i = 1'b1;
        else                    instr_gnt_i = 1'b0;
        if (!rst && mem_q.size() != 0 &&
            (rv_mode == 1 || (rv_mode == 0 && $urandom_range(0, 1) == 1))) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = f(mem_q[0]);
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = $urandom;
        end
        if (rnd_stall) stall_ctrl = ($urandom_range(0, 3) == 0);
        if (rnd_branch) begin
            branch_taken_i  = ($urandom_range(0, 99) < 4);
            branch_target_i = $urandom;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        p_rst = rst;  p_req = instr_req_o;  p_addr = instr_addr_o;  p_gnt = instr_gnt_i;
        p_rv = instr_rvalid_i;  p_stall = stall_ctrl;  p_br = branch_taken_i;  p_tgt = branch_target_i;
        p_valid = instr_valid_o;  p_pc = program_count_o;  p_pc4 = pc_plus4_o;  p_ins = instruction_o;
        if (!p_rst) begin
            if (p_valid) begin
                chk("head_pc", p_pc, exp_pc);
                chk("head_pc4", p_pc4, exp_pc + 32'd4);
                chk("head_instr", p_ins, f(exp_pc));
            end else begin
                chk("nop_when_invalid", p_ins, NOP);
            end
        end
        @(posedge clk);
        #1;
        if (p_rst) begin
            mem_q.delete();
            outst = 0;  exp_pc = BOOT;  exp_fetch = BOOT;  skip_one = 1'b0;
            chk("rst_valid", instr_valid_o, 0);
            chk("rst_instr", instruction_o, NOP);
            chk("rst_req", instr_req_o, 0);
            chk("rst_addr", instr_addr_o, BOOT);
            chk("rst_pc", program_count_o, 0);
            chk("rst_pc4", pc_plus4_o, 4);
        end else begin
            if (p_rv) begin
                void'(mem_q.pop_front());
                outst--;
            end
            if (p_req && p_gnt) begin
                mem_q.push_back(p_addr);
                outst++;
                if (skip_one) skip_one = 1'b0;
                else begin
                    chk("grant_addr", p_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (p_addr == 32'h0 && last_grant == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                last_grant = p_addr;
                chk("outstanding_cap", 32'(outst <= D), 1);
            end
            if (p_req && !p_gnt) begin
                chk("req_held", instr_req_o, 1);
                chk("addr_held", instr_addr_o, p_addr);
            end
            if (p_br) begin
                exp_pc    = p_tgt & ~32'h3;
                exp_fetch = exp_pc;
                if (p_req && !p_gnt) skip_one = 1'b1;
                chk("flush_valid", instr_valid_o, 0);
            end else begin
                if (p_valid && !p_stall) begin
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
                if (p_stall) begin
                    chk("hold_valid", instr_valid_o, p_valid);
                    chk("hold_pc", program_count_o, p_pc);
                    chk("hold_pc4", pc_plus4_o, p_pc4);
                    chk("hold_instr", instruction_o, p_ins);
                end
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1;  stall_ctrl = 1'b0;  branch_taken_i = 1'b0;  branch_target_i = '0;
        instr_gnt_i = 1'b0;  instr_rvalid_i = 1'b0;  instr_rdata_i = '0;
        gnt_mode = 1;  rv_mode = 1;  rnd_stall = 1'b0;  rnd_branch = 1'b0;
        outst = 0;  consumed = 0;  saw_wrap = 1'b0;  last_grant = '0;  skip_one = 1'b0;
        exp_pc = BOOT;  exp_fetch = BOOT;

        step(2);
        rst = 1'b0;
        step(1);
        chk("first_req", instr_req_o, 1);
        chk("first_addr", instr_addr_o, BOOT);
        step(2);
        chk("first_valid", instr_valid_o, 1);
        chk("first_pc", program_count_o, 32'h80);
        chk("first_pc4", pc_plus4_o, 32'h84);
        chk("first_instr", instruction_o, f(32'h80));
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("stream_no_bubble", instr_valid_o, 1);
        end

        stall_ctrl = 1'b1;
        step(5);
        chk("stall_req_drop", instr_req_o, 0);
        stall_ctrl = 1'b0;
        step(4);

        rv_mode = 2;
        step(4);
        chk("two_outstanding", 32'(outst), 2);
        rv_mode = 1;
        branch_taken_i = 1'b1;  branch_target_i = 32'h0000_1002;
        step(1);
        branch_taken_i = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (instr_valid_o) begin got = 1'b1; break; end
        end
        chk("branch_wait", 32'(got), 1);
        if (got) begin
            chk("branch_pc", program_count_o, 32'h1000);
            chk("branch_pc4", pc_plus4_o, 32'h1004);
        end
        step(4);

        gnt_mode = 2;
        step(2);
        chk("pend_req", instr_req_o, 1);
        a_old = instr_addr_o;
        branch_taken_i = 1'b1;  branch_target_i = 32'h0000_2000;
        step(1);
        branch_taken_i = 1'b0;
        step(1);
        chk("pend_addr_kept", instr_addr_o, a_old);
        gnt_mode = 1;
        step(1);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_req_o) begin got = 1'b1; break; end
            step(1);
        end
        chk("target_req_wait", 32'(got), 1);
        if (got) chk("target_addr", instr_addr_o, 32'h2000);
        step(6);

        branch_taken_i = 1'b1;  branch_target_i = 32'hFFFF_FFFE;
        step(1);
        branch_taken_i = 1'b0;
        step(12);
        chk("wrap_seen", 32'(saw_wrap), 1);

        gnt_mode = 0;  rv_mode = 0;  rnd_stall = 1'b1;  rnd_branch = 1'b1;
        step(600);
        rnd_stall = 1'b0;  rnd_branch = 1'b0;  stall_ctrl = 1'b0;  branch_taken_i = 1'b0;
        gnt_mode = 1;  rv_mode = 1;
        c0 = consumed;
        step(40);
        chk("drain_progress", 32'((consumed - c0) >= 20), 1);

        stall_ctrl = 1'b1;
        step(6);
        chk("full_req_low", instr_req_o, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;  stall_ctrl = 1'b0;
        step(1);
        chk("restart_req", instr_req_o, 1);
        chk("restart_addr", instr_addr_o, BOOT);
        step(2);
        chk("restart_valid", instr_valid_o, 1);
        chk("restart_pc", program_count_o, BOOT);
        step(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
